// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants.
// Imported by the fetch controller and its bench.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } state_t;

  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding read per PC,
// holds the word for decode, redirects squash stale fetches.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  output logic               mem_req_valid,
  output logic [ADDR_W-1:0]  mem_req_addr,
  input  logic               mem_req_ready,
  input  logic               mem_resp_valid,
  input  logic [INSTR_W-1:0] mem_resp_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready,
  output logic [31:0]        fetch_count
);

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc, pc_n;
  logic [ADDR_W-1:0] rd_pc;
  logic              squash, squash_n;
  logic              take;
  logic              deliver;

  assign rd_pc = {redirect_pc[ADDR_W-1:2], 2'b00};

  assign mem_req_valid = (state == REQ);
  assign mem_req_addr  = pc;
  assign instr_valid   = (state == HOLD);

  // next state, pc and squash; redirect has priority everywhere
  always_comb begin
    state_n  = state;
    pc_n     = pc;
    squash_n = squash;
    take     = 1'b0;
    deliver  = 1'b0;
    unique case (state)
      IDLE: begin
        if (redirect_valid) pc_n = rd_pc;
        if (enable) state_n = REQ;
      end
      REQ: begin
        if (redirect_valid) begin
          pc_n = rd_pc;
          if (mem_req_ready) begin
            state_n  = WAIT;
            squash_n = 1'b1;
          end
        end else if (mem_req_ready) begin
          state_n = WAIT;
        end else if (!enable) begin
          state_n = IDLE;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_n = rd_pc;
          if (mem_resp_valid) begin
            squash_n = 1'b0;
            state_n  = REQ;
          end else begin
            squash_n = 1'b1;
          end
        end else if (mem_resp_valid) begin
          if (squash) begin
            squash_n = 1'b0;
            state_n  = enable ? REQ : IDLE;
          end else begin
            take    = 1'b1;
            state_n = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_n    = rd_pc;
          state_n = REQ;
        end else if (instr_ready) begin
          pc_n    = pc + ADDR_W'(PC_STEP);
          deliver = 1'b1;
          state_n = enable ? REQ : IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // state, pc and the presented instruction registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      squash      <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      fetch_count <= '0;
    end else begin
      state  <= state_n;
      pc     <= pc_n;
      squash <= squash_n;
      if (take) begin
        instr    <= mem_resp_data;
        instr_pc <= pc;
      end
      if (deliver) fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: scripted memory/decoder stimulus,
// delivered instructions checked against an expected queue.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        mem_req_valid;
  logic [63:0] mem_req_addr;
  logic        mem_req_ready = 1'b0;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic [31:0] fetch_count;

  int vecs = 0;
  int errs = 0;
  int accepts = 0;
  logic [95:0] exp_q[$];

  fetch_ctrl #(.ADDR_W(64), .RESET_PC(64'h0)) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .mem_req_ready (mem_req_ready),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_data (mem_resp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_ready   (instr_ready),
    .fetch_count   (fetch_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  // decoder-side scoreboard: every accepted delivery pops one entry
  always @(negedge clk) begin
    if (!reset && mem_req_valid === 1'b1 && mem_req_ready === 1'b1)
      accepts++;
    if (!reset && instr_valid === 1'b1 && instr_ready === 1'b1 &&
        redirect_valid !== 1'b1) begin
      logic [95:0] e;
      vecs++;
      if (exp_q.size() == 0) begin
        errs++;
        $display("FAIL unexpected_delivery pc=%h instr=%h", instr_pc, instr);
      end else begin
        e = exp_q.pop_front();
        if (instr_pc !== e[95:32] || instr !== e[31:0]) begin
          errs++;
          $display("FAIL delivery got pc=%h instr=%h want pc=%h instr=%h",
                   instr_pc, instr, e[95:32], e[31:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic serve(input logic [63:0] a, input logic [31:0] d,
                       input int lat, input int hold_off);
    int n;
    n = 0;
    while (mem_req_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    vecs++;
    if (mem_req_valid !== 1'b1) begin
      errs++;
      $display("FAIL req_timeout got valid=%b want 1", mem_req_valid);
    end
    vecs++;
    if (mem_req_addr !== a) begin
      errs++;
      $display("FAIL req_addr got %h want %h", mem_req_addr, a);
    end
    for (int i = 0; i < hold_off; i++) begin
      step();
      vecs++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== a) begin
        errs++;
        $display("FAIL req_stable got v=%b a=%h want v=1 a=%h",
                 mem_req_valid, mem_req_addr, a);
      end
    end
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    vecs++;
    if (mem_req_valid !== 1'b0) begin
      errs++;
      $display("FAIL req_after_accept got %b want 0", mem_req_valid);
    end
    repeat (lat - 1) step();
    mem_resp_valid = 1'b1;
    mem_resp_data  = d;
    step();
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    vecs++;
    if (mem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
      errs++;
      $display("FAIL reset_valids got req=%b iv=%b want 0 0",
               mem_req_valid, instr_valid);
    end
    vecs++;
    if (mem_req_addr !== 64'h0 || instr_pc !== 64'h0) begin
      errs++;
      $display("FAIL reset_addrs got %h %h want 0 0", mem_req_addr, instr_pc);
    end
    vecs++;
    if (instr !== 32'h0 || fetch_count !== 32'h0) begin
      errs++;
      $display("FAIL reset_regs got %h %h want 0 0", instr, fetch_count);
    end
  endtask

  task automatic test_basic();
    enable = 1'b1;
    instr_ready = 1'b1;
    reset = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      logic [63:0] a;
      a = 64'(i * 4);
      exp_q.push_back({a, 32'h0000_0013});
      serve(a, 32'h0000_0013, 1, 0);
      vecs++;
      if (instr_valid !== 1'b1 || instr_pc !== a) begin
        errs++;
        $display("FAIL basic_hold got iv=%b pc=%h want 1 %h",
                 instr_valid, instr_pc, a);
      end
      step();
      vecs++;
      if (mem_req_valid !== 1'b1 || fetch_count !== 32'(i + 1)) begin
        errs++;
        $display("FAIL basic_next got req=%b cnt=%0d want 1 %0d",
                 mem_req_valid, fetch_count, i + 1);
      end
    end
  endtask

  task automatic test_stall();
    instr_ready = 1'b0;
    exp_q.push_back({64'hC, 32'hA5A5_5A5A});
    serve(64'hC, 32'hA5A5_5A5A, 2, 0);
    for (int i = 0; i < 5; i++) begin
      vecs++;
      if (instr_valid !== 1'b1 || instr !== 32'hA5A5_5A5A ||
          instr_pc !== 64'hC || mem_req_valid !== 1'b0 ||
          fetch_count !== 32'd3) begin
        errs++;
        $display("FAIL stall got iv=%b i=%h pc=%h rq=%b c=%0d want 1 a5a55a5a c 0 3",
                 instr_valid, instr, instr_pc, mem_req_valid, fetch_count);
      end
      step();
    end
    instr_ready = 1'b1;
    step();
    vecs++;
    if (fetch_count !== 32'd4 || mem_req_valid !== 1'b1 ||
        mem_req_addr !== 64'h10) begin
      errs++;
      $display("FAIL stall_release got c=%0d rq=%b a=%h want 4 1 10",
               fetch_count, mem_req_valid, mem_req_addr);
    end
  endtask

  task automatic test_redirect_wait();
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 64'h1002;
    step();
    redirect_valid = 1'b0;
    redirect_pc = '0;
    step();
    step();
    mem_resp_valid = 1'b1;
    mem_resp_data = 32'hDEAD_BEEF;
    step();
    mem_resp_valid = 1'b0;
    mem_resp_data = '0;
    vecs++;
    if (instr_valid !== 1'b0 || instr !== 32'hA5A5_5A5A) begin
      errs++;
      $display("FAIL squash_drop got iv=%b i=%h want 0 a5a55a5a",
               instr_valid, instr);
    end
    vecs++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h1000) begin
      errs++;
      $display("FAIL squash_req got rq=%b a=%h want 1 1000",
               mem_req_valid, mem_req_addr);
    end
    exp_q.push_back({64'h1000, 32'h0000_0093});
    serve(64'h1000, 32'h0000_0093, 1, 0);
    step();
    vecs++;
    if (fetch_count !== 32'd5) begin
      errs++;
      $display("FAIL squash_count got %0d want 5", fetch_count);
    end
  endtask

  task automatic test_redirect_hold();
    instr_ready = 1'b0;
    serve(64'h1004, 32'h1111_1111, 1, 0);
    instr_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 64'h200;
    step();
    redirect_valid = 1'b0;
    redirect_pc = '0;
    vecs++;
    if (instr_valid !== 1'b0 || fetch_count !== 32'd5) begin
      errs++;
      $display("FAIL hold_redirect got iv=%b c=%0d want 0 5",
               instr_valid, fetch_count);
    end
    vecs++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h200) begin
      errs++;
      $display("FAIL hold_redirect_req got rq=%b a=%h want 1 200",
               mem_req_valid, mem_req_addr);
    end
  endtask

  task automatic test_req_stall();
    int a0;
    a0 = accepts;
    exp_q.push_back({64'h200, 32'h2222_2222});
    serve(64'h200, 32'h2222_2222, 1, 4);
    step();
    vecs++;
    if (accepts - a0 != 1 || fetch_count !== 32'd6) begin
      errs++;
      $display("FAIL req_stall got acc=%0d c=%0d want 1 6",
               accepts - a0, fetch_count);
    end
    vecs++;
    if (mem_req_addr !== 64'h204) begin
      errs++;
      $display("FAIL req_stall_next got %h want 204", mem_req_addr);
    end
  endtask

  task automatic test_reset_mid_wait();
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    reset = 1'b1;
    enable = 1'b0;
    step();
    reset = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data = 32'hCAFE_F00D;
    step();
    mem_resp_valid = 1'b0;
    mem_resp_data = '0;
    step();
    vecs++;
    if (mem_req_valid !== 1'b0 || instr_valid !== 1'b0 ||
        mem_req_addr !== 64'h0) begin
      errs++;
      $display("FAIL rst_wait_ctl got rq=%b iv=%b a=%h want 0 0 0",
               mem_req_valid, instr_valid, mem_req_addr);
    end
    vecs++;
    if (instr !== 32'h0 || instr_pc !== 64'h0 || fetch_count !== 32'h0) begin
      errs++;
      $display("FAIL rst_wait_regs got i=%h pc=%h c=%0d want 0 0 0",
               instr, instr_pc, fetch_count);
    end
  endtask

  task automatic test_wrap();
    enable = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    redirect_valid = 1'b0;
    redirect_pc = '0;
    vecs++;
    if (mem_req_valid !== 1'b1 ||
        mem_req_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      errs++;
      $display("FAIL wrap_req got rq=%b a=%h want 1 fffffffffffffffc",
               mem_req_valid, mem_req_addr);
    end
    exp_q.push_back({64'hFFFF_FFFF_FFFF_FFFC, 32'h0000_0033});
    serve(64'hFFFF_FFFF_FFFF_FFFC, 32'h0000_0033, 1, 0);
    step();
    vecs++;
    if (mem_req_addr !== 64'h0 || fetch_count !== 32'd1) begin
      errs++;
      $display("FAIL wrap_next got a=%h c=%0d want 0 1",
               mem_req_addr, fetch_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_req_stall();
    test_reset_mid_wait();
    test_wrap();
    vecs++;
    if (exp_q.size() != 0) begin
      errs++;
      $display("FAIL pending_expected got %0d want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction fetch controller that sequences the decode stage: it issues one 32-bit instruction read per program counter to the memory port, captures the returned word, and holds it stable for the decoder until the decoder accepts it. It owns the PC, advances it by 4 per delivered instruction, and handles control-flow redirects, squashing any stale in-flight fetch. Sits between the instruction memory interface and the decoder.

## Interface
- RESET_PC, 64'h0, PC loaded on reset
- ADDR_W, 64, PC / address width
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- enable  in  1  fetch permitted; low parks the block in IDLE once no fetch is outstanding
- mem_req_valid  out  1  read request to instruction memory
- mem_req_addr  out  ADDR_W  request address, bits [1:0] always 0
- mem_req_ready  in  1  memory accepts request this cycle
- mem_resp_valid  in  1  read data valid (one response per accepted request, any latency ≥1)
- mem_resp_data  in  32  instruction word
- redirect_valid  in  1  branch/jump redirect, single-cycle pulse
- redirect_pc  in  ADDR_W  redirect target; bits [1:0] forced to 0 internally
- instr_valid  out  1  instruction presented to decoder
- instr  out  32  instruction word to decoder
- instr_pc  out  ADDR_W  PC of presented instruction
- instr_ready  in  1  decoder accepts instruction
- fetch_count  out  32  instructions delivered since reset, wraps at 2^32

## Operation
- State machine: IDLE, REQ, WAIT, HOLD.
- IDLE: outputs quiet. enable=1 → REQ.
- REQ: mem_req_valid=1, mem_req_addr=pc. mem_req_ready=1 → WAIT. enable=0 with no accept → IDLE.
- WAIT: on mem_resp_valid, latch data into instr, pc into instr_pc → HOLD. If squash flag set, discard response, clear squash → REQ (or IDLE if enable=0).
- HOLD: instr_valid=1; instr/instr_pc stable. instr_ready=1 → pc+=4, fetch_count+=1, → REQ (IDLE if enable=0).
- Redirect (highest priority, any state): pc ← {redirect_pc[ADDR_W-1:2],2'b00}.
  - IDLE: pc updated, stays IDLE.
  - REQ: stays REQ; new address driven next cycle (only case in which address may change while valid). Redirect coincident with mem_req_ready: request counts as accepted, → WAIT with squash set.
  - WAIT: set squash; stay WAIT until response arrives. Redirect coincident with mem_resp_valid: response discarded, → REQ.
  - HOLD: instr_valid drops next cycle, → REQ. Redirect coincident with instr_ready: redirect wins; instruction not counted, pc not incremented.
- mem_resp_valid outside WAIT is ignored.
- enable=0 in WAIT: response still awaited and consumed (delivered via HOLD unless squashed).
- PC arithmetic modulo 2^ADDR_W; wraps from all-ones-minus-3 to 0.

## Timing
- Reset values: state IDLE, pc=RESET_PC, mem_req_valid=0, mem_req_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, fetch_count=0, squash=0.
- Reset mid-operation: returns to IDLE next edge; any pending response is dropped (memory is reset by the same reset).
- Best case per instruction: REQ accepted cycle t, response t+1, instr_valid t+2, accepted t+2, next request t+3 → 3 cycles/instruction; single outstanding request.
- Redirect at cycle t → mem_req_valid with new address at t+1 (from REQ/HOLD/IDLE-with-enable).
- instr_valid is registered; no combinational path from mem_resp_* or instr_ready to any output.

## Structure
- Shared package fetch_pkg: state enum (IDLE, REQ, WAIT, HOLD), INSTR_W=32, PC_STEP=4.
- Single flat module; no sub-module needed.

## Test plan
- Reset, enable=1, memory 1-cycle latency returning 32'h00000013 at 0x0, 0x4, decoder always ready → instr_pc 0x0, 0x4, 0x8 on successive 3-cycle deliveries, fetch_count=3 after third.
- Decoder stalls instr_ready low 5 cycles in HOLD → instr/instr_pc unchanged, no new mem_req_valid, count unchanged.
- Redirect to 0x1002 during WAIT, response 32'hDEADBEEF arrives 3 cycles later → response discarded, next request addr 0x1000, instr_valid never asserted for DEADBEEF.
- Redirect to 0x200 same cycle as instr_ready in HOLD → fetch_count unchanged, next mem_req_addr 0x200.
- mem_req_ready held low 4 cycles then high → mem_req_valid and address stable throughout; exactly one request accepted.
- Reset asserted mid-WAIT, response arrives next cycle → ignored, all outputs at reset values, pc=RESET_PC.
